// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - run/step/halt clock-enable controller between divider and CPU
module cpu_clock_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             div_clk,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_halt,
    input  logic             sw_fast,
    output logic             choose,
    output logic             cpu_clk_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    // Counter only has to reach DEBOUNCE_CYCLES-1 before it clears.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } state_t;

    // Channel order: 0 run, 1 step, 2 halt, 3 speed switch.
    logic [3:0]      raw;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      db;
    logic [2:0]      db_d;
    logic [DB_W-1:0] db_cnt [4];

    logic            div_s1;
    logic            div_s2;
    logic            div_d;
    logic            tick;
    logic            tick_r;

    logic            run_p;
    logic            step_p;
    logic            halt_p;

    state_t          cur;
    state_t          nxt;
    logic            en_nxt;

    assign raw = {sw_fast, btn_halt, btn_step, btn_run};

    // Two-flop synchronizers for every asynchronous input.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1  <= '0;
            sync2  <= '0;
            div_s1 <= 1'b0;
            div_s2 <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            div_s1 <= div_clk;
            div_s2 <= div_s1;
        end
    end

    // Per-channel debounce: a new level must persist DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_d <= db[2:0];
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Press events fire once on the debounced rising edge; release is silent.
    assign run_p  = db[0] & ~db_d[0];
    assign step_p = db[1] & ~db_d[1];
    assign halt_p = db[2] & ~db_d[2];

    assign choose = db[3];

    // Rising edge of the synchronized divider clock, registered once more so
    // the enable lands on the cycle after edge k+3.
    assign tick = div_s2 & ~div_d;

    // Divider edge detector and tick pipeline stage.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            div_d  <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            div_d  <= div_s2;
            tick_r <= tick;
        end
    end

    // Next-state and enable decision; halt beats run beats step beats tick.
    always_comb begin
        nxt    = cur;
        en_nxt = 1'b0;
        case (cur)
            S_HALT: begin
                if (halt_p) begin
                    nxt = S_HALT;
                end else if (run_p) begin
                    nxt = S_RUN;
                end else if (step_p) begin
                    nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (halt_p) begin
                    nxt = S_HALT;
                end else if (tick_r) begin
                    en_nxt = 1'b1;
                end
            end
            S_STEP: begin
                if (halt_p) begin
                    nxt = S_HALT;
                end else if (run_p) begin
                    nxt = S_RUN;
                end else if (tick_r) begin
                    en_nxt = 1'b1;
                    nxt    = S_HALT;
                end
            end
            default: nxt = S_HALT;
        endcase
    end

    // State register, registered enable and executed-cycle counter.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cur         <= S_HALT;
            cpu_clk_en  <= 1'b0;
            cycle_count <= '0;
        end else begin
            cur        <= nxt;
            cpu_clk_en <= en_nxt;
            if (en_nxt) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb/tb_cpu_clock_ctrl.sv - scoreboard bench for cpu_clock_ctrl
module tb_cpu_clock_ctrl;

    localparam int DB = 4;
    localparam int CW = 4;

    logic          clk_in = 1'b0;
    logic          rst = 1'b0;
    logic          div_clk = 1'b0;
    logic          btn_run = 1'b0;
    logic          btn_step = 1'b0;
    logic          btn_halt = 1'b0;
    logic          sw_fast = 1'b0;
    logic          choose;
    logic          cpu_clk_en;
    logic [1:0]    state;
    logic [CW-1:0] cycle_count;

    cpu_clock_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .div_clk     (div_clk),
        .btn_run     (btn_run),
        .btn_step    (btn_step),
        .btn_halt    (btn_halt),
        .sw_fast     (sw_fast),
        .choose      (choose),
        .cpu_clk_en  (cpu_clk_en),
        .state       (state),
        .cycle_count (cycle_count)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int at;
        int cnt;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    // Reference model: mode 0 halt, 1 run, 2 step.
    int m_mode = 0;
    int m_cnt = 0;
    bit m_sw = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Monitor: every enable pulse must match the oldest expectation.
    bit prev_en = 0;
    always @(negedge clk_in) begin
        if (!rst) begin
            prev_en = 0;
        end else begin
            if (cpu_clk_en) begin
                check("single_cycle_pulse", prev_en, 0);
                check("pulse_expected", int'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check("pulse_cycle", cyc, e.at);
                    check("pulse_count", cycle_count, e.cnt);
                end
            end
            if (sbq.size() > 0 && sbq[0].at < cyc) begin
                e = sbq.pop_front();
                check("pulse_missing_at", cyc, e.at);
            end
            prev_en = cpu_clk_en;
        end
    end

    // which: 0 run, 1 step, 2 halt, 3 run+step together
    task automatic press(input int which);
        @(negedge clk_in);
        btn_run  = (which == 0 || which == 3);
        btn_step = (which == 1 || which == 3);
        btn_halt = (which == 2);
        idle(10);
        btn_run = 0; btn_step = 0; btn_halt = 0;
        idle(12);
        case (which)
            0, 3: m_mode = 1;
            1: if (m_mode == 0) m_mode = 2;
            default: m_mode = 0;
        endcase
        check("state_after_press", state, m_mode);
    endtask

    task automatic tick_op(input int hi, input int lo);
        @(negedge clk_in);
        div_clk = 1;
        if (m_mode != 0) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            sbq.push_back('{cyc + 4, m_cnt});
            if (m_mode == 2) m_mode = 0;
        end
        idle(hi);
        div_clk = 0;
        idle(lo);
        check("state_after_tick", state, m_mode);
    endtask

    task automatic toggle_sw();
        @(negedge clk_in);
        m_sw = ~m_sw;
        sw_fast = m_sw;
        idle(10);
        check("choose", choose, int'(m_sw));
        check("state_after_sw", state, m_mode);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end

    initial begin
        idle(5);
        check("reset_state", state, 0);
        check("reset_en", cpu_clk_en, 0);
        check("reset_count", cycle_count, 0);
        check("reset_choose", choose, 0);
        rst = 1;

        // Idle in HALT with the divider running: nothing may happen.
        for (int i = 0; i < 3; i++) tick_op(9, 10);
        check("idle_count", cycle_count, 0);
        check("idle_choose", choose, 0);

        // Short glitch on run never reaches the FSM.
        @(negedge clk_in);
        btn_run = 1;
        idle(3);
        btn_run = 0;
        idle(12);
        check("glitch_state", state, 0);

        // Run with five ticks, then halt.
        press(0);
        for (int i = 0; i < 5; i++) tick_op(3, 4);
        check("run_count", cycle_count, 5);
        press(2);
        tick_op(3, 4);

        // Single step, with a second step press while already in STEP.
        press(1);
        press(1);
        tick_op(3, 4);
        tick_op(3, 4);
        check("step_count", cycle_count, m_cnt);

        // Halt press lands on the same FSM cycle as a tick.
        press(0);
        @(negedge clk_in);
        btn_halt = 1;
        idle(3);
        div_clk = 1;
        m_mode = 0;
        idle(7);
        btn_halt = 0;
        div_clk = 0;
        idle(12);
        check("halt_vs_tick_state", state, 0);
        check("halt_vs_tick_count", cycle_count, m_cnt);

        // Run and step together from HALT.
        press(3);
        check("run_step_state", state, 1);

        // Randomized mix.
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) press(r);
            else if (r == 4) toggle_sw();
            else tick_op($urandom_range(2, 5), $urandom_range(3, 6));
        end

        // Async reset mid-RUN, with choose forced high beforehand.
        if (!m_sw) toggle_sw();
        press(0);
        tick_op(3, 4);
        idle(6);
        @(posedge clk_in);
        #3;
        rst = 0;
        sw_fast = 0;
        #1;
        check("async_state", state, 0);
        check("async_en", cpu_clk_en, 0);
        check("async_count", cycle_count, 0);
        check("async_choose", choose, 0);
        m_mode = 0; m_cnt = 0; m_sw = 0;
        @(negedge clk_in);
        rst = 1;

        // Wrap: 17 pulses on a 4-bit counter.
        press(0);
        for (int i = 0; i < 17; i++) tick_op(2, 3);
        idle(2);
        check("wrap_count", cycle_count, 1);

        // A pending step is dropped by reset.
        press(2);
        press(1);
        @(negedge clk_in);
        rst = 0;
        m_mode = 0;
        @(negedge clk_in);
        rst = 1;
        m_cnt = 0;
        tick_op(3, 4);
        check("reset_drops_step", cycle_count, 0);

        idle(10);
        check("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
Run/step/halt controller between the clock divider and the single-cycle CPU. It debounces the board buttons and the speed switch, and drives the divider's speed-select input (choose). It converts the divider's slow output clock into a one-cycle clock-enable for the CPU in free-run or single-step mode, and counts executed CPU cycles for the display.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clk_in cycles a synchronized input must hold a new level before the debounced level changes (benches use 4)
CNT_W, 32, width of cycle_count

Ports:
clk_in  input  1  board system clock
rst  input  1  asynchronous, active-low reset
div_clk  input  1  divided clock from the divider (asynchronous to this block's logic)
btn_run  input  1  raw run button, active-high
btn_step  input  1  raw single-step button, active-high
btn_halt  input  1  raw halt button, active-high
sw_fast  input  1  raw speed switch, 1 = fast
choose  output  1  debounced sw_fast, to divider speed select
cpu_clk_en  output  1  one-clk_in-cycle CPU clock-enable pulse
state  output  2  00 HALT, 01 RUN, 10 STEP
cycle_count  output  CNT_W  number of cpu_clk_en pulses since reset

Behaviour:
- Reset (rst=0, async): all flops clear.
  - choose=0, cpu_clk_en=0, state=HALT, cycle_count=0, debounced levels=0, debounce counters=0.
  - A reset asserted mid-operation takes effect immediately and drops any pending step.
- Synchronization:
  - div_clk, btn_run, btn_step, btn_halt and sw_fast each pass through a 2-flop synchronizer on clk_in.
- Debounce (per button/switch):
  - Counter resets whenever the synchronized value equals the debounced level.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change the debounced level.
- Press events:
  - run_p, step_p and halt_p are 1-cycle pulses on the rising edge of each debounced button. Release generates nothing.
- choose = debounced sw_fast (registered).
- Tick detection:
  - tick = synchronized div_clk AND NOT its one-cycle-delayed copy (rising edge only).
  - div_clk falling edges are ignored.
- FSM (registered, evaluated every clk_in edge). Priority within a cycle: halt_p > run_p > step_p > tick.
  - HALT: run_p -> RUN; else step_p -> STEP; else stay. No pulses.
  - RUN: halt_p -> HALT, no pulse that cycle even if tick. Else tick -> cpu_clk_en pulse, stay RUN. step_p is ignored.
  - STEP: halt_p -> HALT, no pulse. Else run_p -> RUN. Else tick -> cpu_clk_en pulse and return to HALT. Additional step_p are ignored while in STEP.
- cpu_clk_en:
  - Registered, high for exactly one clk_in cycle per qualifying tick; never high on consecutive cycles.
  - Latency: if div_clk is first sampled high at clk_in edge k, cpu_clk_en is high for the cycle following edge k+3.
- cycle_count:
  - Increments by 1 on the same edge that registers cpu_clk_en=1.
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared only by reset; not cleared by HALT.
- Speed change:
  - Toggling sw_fast only changes choose. FSM state and the counter are unaffected.

Test Plan:
- Reset/idle: DEBOUNCE_CYCLES=4, rst=0 then 1, div_clk toggling every 10 cycles, no buttons -> state=00, cpu_clk_en never 1, cycle_count=0, choose=0.
- Debounce: btn_run high for 3 cycles, then low -> state stays 00. btn_run held high for 10 cycles -> state=01 within 2+4+1 cycles of assertion.
- Run: in RUN, 5 div_clk rising edges -> exactly 5 single-cycle cpu_clk_en pulses, each 4 edges after the div_clk rise, cycle_count=5. Press btn_halt -> state=00, no further pulses.
- Single step: from HALT press btn_step -> state=10 and one pulse on the next div_clk rise, then state=00, cycle_count+1. A second step press while in STEP -> still only one pulse.
- Simultaneous: halt_p coincident with tick in RUN -> no pulse, state=00. run and step pressed together in HALT -> state=01.
- Wrap/async reset: CNT_W=4, 17 ticks in RUN -> cycle_count=1. Assert rst mid-RUN between clk_in edges -> all outputs zero immediately.
